psi_rx_deframer: RTL and testbench

- Serial-to-parallel receiver for the PSI serial link; the far end of the psi serial output.
- Hunts the idle-low line for the SOF dword, then collects data dwords LSB-first until the EOF sequence.
- Presents each data dword on a parallel port as a one-cycle valid pulse, with last marking the packet's final dword.
- Sits on the serial clock domain. There is no backpressure, because the serial link cannot stall.

---
 rtl/psi_rx_deframer_pkg.sv | 18 +
 rtl/psi_rx_deframer_shifter.sv | 54 +++++
 rtl/psi_rx_deframer.sv | 210 +++++++++++++++++++++
 tb/tb_psi_rx_deframer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/psi_rx_deframer_pkg.sv
// Shared PSI link constants and receiver state encoding.
// The encodings and patterns match the transmitter's IDLE/SOF/DATA/EOF defines.
package psi_rx_deframer_pkg;

   localparam int          PSI_DSIZE    = 32;
   localparam int          PSI_PSIZE    = 128;
   localparam int          PSI_BIT_W    = 5;
   localparam logic [31:0] PSI_SOF_PAT  = 32'h5a5a5a5a;
   localparam logic [31:0] PSI_EOF_PAT  = 32'h0f0f0f0f;
   localparam logic [15:0] PSI_EOF_TAIL = 16'h0f0f;

   typedef enum logic [1:0] {
      ST_HUNT     = 2'd0,
      ST_DATA     = 2'd1,
      ST_EOF_TAIL = 2'd2
   } psi_rx_state_e;

endpackage

// File: rtl/psi_rx_deframer_shifter.sv
// Serial shift register, bit counter and framing-pattern match flags for the PSI receiver.
module psi_rx_shifter
   import psi_rx_deframer_pkg::*;
#(
   parameter logic [31:0] SOF_PAT = PSI_SOF_PAT,
   parameter logic [31:0] EOF_PAT = PSI_EOF_PAT
) (
   input  logic                 s_clk,
   input  logic                 n_rst,
   input  logic                 s_data,
   input  logic                 sr_clr,
   input  logic                 cnt_clr,
   input  logic                 cnt_load16,
   output logic [31:0]          w,
   output logic [PSI_BIT_W-1:0] bit_cnt,
   output logic                 sof_hit,
   output logic                 eof_hit,
   output logic                 tail_hit
);

   logic [31:0]          sr_q, sr_d;
   logic [PSI_BIT_W-1:0] bit_cnt_q, bit_cnt_d;

   // w is the post-shift view, so matches see the bit being sampled this edge
   always_comb begin
      w = {s_data, sr_q[31:1]};
   end

   always_comb begin
      sr_d      = sr_clr ? '0 : w;
      bit_cnt_d = bit_cnt_q + PSI_BIT_W'(1);
      if (cnt_clr) begin
         bit_cnt_d = '0;
      end else if (cnt_load16) begin
         bit_cnt_d = PSI_BIT_W'(16);
      end
   end

   always_ff @(posedge s_clk or negedge n_rst) begin
      if (!n_rst) begin
         sr_q      <= '0;
         bit_cnt_q <= '0;
      end else begin
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign bit_cnt  = bit_cnt_q;
   assign sof_hit  = (w == SOF_PAT);
   assign eof_hit  = (w == EOF_PAT);
   assign tail_hit = (w[31:16] == PSI_EOF_TAIL);

endmodule

// File: rtl/psi_rx_deframer.sv
// PSI serial receiver: hunts SOF, collects LSB-first dwords, emits them until EOF+tail.
// Optional statistics counters are built when PSI_RX_STATS_EN is defined.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_HUNT     | idle line, waiting for the SOF dword
// ST_DATA     | collecting a data dword; one dword is held pending until its successor
// ST_EOF_TAIL | EOF dword seen, checking the 16-bit tail halfword
module psi_rx_deframer
   import psi_rx_deframer_pkg::*;
#(
   parameter int          DSIZE   = PSI_DSIZE,
   parameter int          PSIZE   = PSI_PSIZE,
   parameter logic [31:0] SOF_PAT = PSI_SOF_PAT,
   parameter logic [31:0] EOF_PAT = PSI_EOF_PAT
) (
   input  logic             s_clk,
   input  logic             n_rst,
   input  logic             s_data,
   output logic [DSIZE-1:0] data,
   output logic             valid,
   output logic             last,
   output logic             err
`ifdef PSI_RX_STATS_EN
   ,
   output logic [15:0]      pkt_cnt,
   output logic [31:0]      dw_total,
   output logic [7:0]       err_cnt
`endif
);

   localparam int                DW_W    = $clog2(PSIZE + 1);
   localparam logic [DW_W-1:0]   PSIZE_C = DW_W'(PSIZE);

   psi_rx_state_e        state_q, state_d;
   logic [DSIZE-1:0]     pend_q, pend_d;
   logic                 pend_v_q, pend_v_d;
   logic [DW_W-1:0]      dw_cnt_q, dw_cnt_d;
   logic [DSIZE-1:0]     data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 last_q, last_d;
   logic                 err_q, err_d;

   logic [31:0]          w;
   logic [PSI_BIT_W-1:0] bit_cnt;
   logic                 sof_hit, eof_hit, tail_hit;
   logic                 sr_clr, cnt_clr, cnt_load16;
   logic                 word_done, tail_done, accept, ovf;
   logic [DSIZE-1:0]     acc_word;

   psi_rx_shifter #(
      .SOF_PAT (SOF_PAT),
      .EOF_PAT (EOF_PAT)
   ) u_shifter (
      .s_clk      (s_clk),
      .n_rst      (n_rst),
      .s_data     (s_data),
      .sr_clr     (sr_clr),
      .cnt_clr    (cnt_clr),
      .cnt_load16 (cnt_load16),
      .w          (w),
      .bit_cnt    (bit_cnt),
      .sof_hit    (sof_hit),
      .eof_hit    (eof_hit),
      .tail_hit   (tail_hit)
   );

   // A failed tail means the EOF dword was really data; it is accepted like any other dword
   assign word_done = (state_q == ST_DATA) && (bit_cnt == PSI_BIT_W'(31));
   assign tail_done = (state_q == ST_EOF_TAIL) && (bit_cnt == PSI_BIT_W'(15));
   assign accept    = (word_done && !eof_hit) || (tail_done && !tail_hit);
   assign ovf       = (dw_cnt_q == PSIZE_C);
   assign acc_word  = (state_q == ST_EOF_TAIL) ? DSIZE'(EOF_PAT) : DSIZE'(w);

   always_ff @(posedge s_clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HUNT: begin
            if (sof_hit) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (word_done) begin
               if (eof_hit)  state_d = ST_EOF_TAIL;
               else if (ovf) state_d = ST_HUNT;
            end
         end
         ST_EOF_TAIL: begin
            if (tail_done) begin
               if (tail_hit || ovf) state_d = ST_HUNT;
               else                 state_d = ST_DATA;
            end
         end
         default: state_d = ST_HUNT;
      endcase
   end

   // Clearing sr on HUNT entry keeps leftover tail bits out of the SOF match
   always_comb begin
      sr_clr     = (state_d == ST_HUNT) && (state_q != ST_HUNT);
      cnt_clr    = (state_d == ST_HUNT) || (state_q == ST_HUNT) || (word_done && eof_hit);
      cnt_load16 = tail_done && !tail_hit;
   end

   always_comb begin
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      dw_cnt_d = dw_cnt_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      last_d   = 1'b0;
      err_d    = 1'b0;

      if ((state_q == ST_HUNT) && sof_hit) begin
         pend_v_d = 1'b0;
         dw_cnt_d = '0;
      end

      if (accept) begin
         if (ovf) begin
            err_d    = 1'b1;
            pend_v_d = 1'b0;
         end else begin
            if (pend_v_q) begin
               valid_d = 1'b1;
               data_d  = pend_q;
            end
            pend_d   = acc_word;
            pend_v_d = 1'b1;
            dw_cnt_d = dw_cnt_q + DW_W'(1);
         end
      end

      if (tail_done && tail_hit) begin
         if (pend_v_q) begin
            valid_d = 1'b1;
            last_d  = 1'b1;
            data_d  = pend_q;
         end else begin
            err_d = 1'b1;
         end
         pend_v_d = 1'b0;
      end
   end

   always_ff @(posedge s_clk or negedge n_rst) begin
      if (!n_rst) begin
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         dw_cnt_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         dw_cnt_q <= dw_cnt_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         err_q    <= err_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign last  = last_q;
   assign err   = err_q;

`ifdef PSI_RX_STATS_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [31:0] dw_total_q, dw_total_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   // pkt_cnt and dw_total wrap; err_cnt saturates
   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      dw_total_d = dw_total_q;
      err_cnt_d  = err_cnt_q;
      if (valid_d && last_d)              pkt_cnt_d  = pkt_cnt_q + 16'd1;
      if (valid_d)                        dw_total_d = dw_total_q + 32'd1;
      if (err_d && (err_cnt_q != 8'hff))  err_cnt_d  = err_cnt_q + 8'd1;
   end

   always_ff @(posedge s_clk or negedge n_rst) begin
      if (!n_rst) begin
         pkt_cnt_q  <= '0;
         dw_total_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         pkt_cnt_q  <= pkt_cnt_d;
         dw_total_q <= dw_total_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign pkt_cnt  = pkt_cnt_q;
   assign dw_total = dw_total_q;
   assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_psi_rx_deframer.sv
// Directed bench for psi_rx_deframer with an expected-dword scoreboard.
// Builds with or without PSI_RX_STATS_EN.
module tb_psi_rx_deframer;

   localparam logic [31:0] SOF  = 32'h5a5a5a5a;
   localparam logic [31:0] EOF  = 32'h0f0f0f0f;
   localparam logic [15:0] TAIL = 16'h0f0f;

   logic        s_clk = 1'b0;
   logic        n_rst;
   logic        s_data;
   logic [31:0] data;
   logic        valid;
   logic        last;
   logic        err;
`ifdef PSI_RX_STATS_EN
   logic [15:0] pkt_cnt;
   logic [31:0] dw_total;
   logic [7:0]  err_cnt;
`endif

   psi_rx_deframer dut (
      .s_clk    (s_clk),
      .n_rst    (n_rst),
      .s_data   (s_data),
      .data     (data),
      .valid    (valid),
      .last     (last),
      .err      (err)
`ifdef PSI_RX_STATS_EN
      ,
      .pkt_cnt  (pkt_cnt),
      .dw_total (dw_total),
      .err_cnt  (err_cnt)
`endif
   );

   always #5 s_clk = ~s_clk;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks   = 0;
   int   errors   = 0;
   int   err_seen = 0;
   int   e0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge s_clk) begin
      #1;
      if (valid === 1'b1) begin
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_valid: observed data %h expected no output", data);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_data", data, e.d);
            chk("sb_last", {31'b0, last}, {31'b0, e.l});
            chk("err_with_valid", {31'b0, err}, 32'd0);
         end
      end
      if (err === 1'b1) err_seen++;
   end

   task automatic send_bit(input logic b);
      @(negedge s_clk);
      s_data = b;
   endtask

   task automatic send_dword(input logic [31:0] d);
      for (int i = 0; i < 32; i++) send_bit(d[i]);
   endtask

   task automatic send_half(input logic [15:0] h);
      for (int i = 0; i < 16; i++) send_bit(h[i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0);
   endtask

   task automatic send_frame(input logic [31:0] dws[$]);
      exp_t x;
      send_dword(SOF);
      for (int i = 0; i < dws.size(); i++) begin
         x.d = dws[i];
         x.l = (i == dws.size() - 1);
         sb.push_back(x);
         send_dword(dws[i]);
      end
      send_dword(EOF);
      send_half(TAIL);
   endtask

   initial begin
      exp_t x;
      logic [31:0] big[$];
      n_rst  = 1'b0;
      s_data = 1'b0;
      repeat (3) @(negedge s_clk);
      chk("rst_data",  data, 32'd0);
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_last",  {31'b0, last},  32'd0);
      chk("rst_err",   {31'b0, err},   32'd0);
      n_rst = 1'b1;
      idle(8);

      // basic 3-dword frame with latency checks
      e0 = err_seen;
      send_dword(SOF);
      x = '{d: 32'h12345678, l: 1'b0}; sb.push_back(x); send_dword(32'h12345678);
      x = '{d: 32'hdeadbeef, l: 1'b0}; sb.push_back(x); send_dword(32'hdeadbeef);
      @(posedge s_clk); #1;
      chk("lat_mid_valid", {31'b0, valid}, 32'd1);
      chk("lat_mid_data",  data, 32'h12345678);
      x = '{d: 32'h00000001, l: 1'b1}; sb.push_back(x); send_dword(32'h00000001);
      send_dword(EOF);
      send_half(TAIL);
      @(posedge s_clk); #1;
      chk("lat_last_valid", {31'b0, valid}, 32'd1);
      chk("lat_last_last",  {31'b0, last},  32'd1);
      idle(6);
      chk("t1_sb_empty", 32'(sb.size()), 32'd0);
      chk("t1_no_err",   32'(err_seen - e0), 32'd0);

      // data dword equal to EOF_PAT followed by non-tail dword
      e0 = err_seen;
      send_frame('{32'h11111111, 32'h0f0f0f0f, 32'haaaa5555, 32'h22222222});
      idle(6);
      chk("t2_sb_empty", 32'(sb.size()), 32'd0);
      chk("t2_no_err",   32'(err_seen - e0), 32'd0);

      // empty packet then good packet
      e0 = err_seen;
      send_dword(SOF);
      send_dword(EOF);
      send_half(TAIL);
      idle(6);
      chk("t3_empty_err", 32'(err_seen - e0), 32'd1);
      send_frame('{32'hcafef00d, 32'h0badc0de});
      idle(6);
      chk("t3_sb_empty", 32'(sb.size()), 32'd0);
      chk("t3_err_once", 32'(err_seen - e0), 32'd1);

      // PSIZE overflow: 129 dwords, first 127 emitted
      e0 = err_seen;
      send_dword(SOF);
      for (int i = 1; i <= 129; i++) begin
         if (i <= 127) begin
            x = '{d: 32'h1000_0000 + 32'(i), l: 1'b0};
            sb.push_back(x);
         end
         send_dword(32'h1000_0000 + 32'(i));
      end
      idle(6);
      chk("t4_ovf_err",  32'(err_seen - e0), 32'd1);
      chk("t4_sb_empty", 32'(sb.size()), 32'd0);
      idle(8);
      send_frame('{32'h3333cccc});
      idle(6);
      chk("t4_next_pkt", 32'(sb.size()), 32'd0);
      chk("t4_err_once", 32'(err_seen - e0), 32'd1);

      // reset mid-packet drops the pending dword
      e0 = err_seen;
      send_dword(SOF);
      x = '{d: 32'h44444444, l: 1'b0}; sb.push_back(x); send_dword(32'h44444444);
      send_dword(32'h55555555);
      for (int i = 0; i < 10; i++) send_bit(1'b1);
      @(negedge s_clk);
      n_rst = 1'b0;
      #1;
      chk("t5_rst_valid", {31'b0, valid}, 32'd0);
      chk("t5_rst_data",  data, 32'd0);
      repeat (3) @(negedge s_clk);
      n_rst  = 1'b1;
      s_data = 1'b0;
      idle(8);
      send_frame('{32'h66666666, 32'h77777777});
      idle(6);
      chk("t5_sb_empty", 32'(sb.size()), 32'd0);
      chk("t5_no_err",   32'(err_seen - e0), 32'd0);

      // two back-to-back packets after a fresh reset
      @(negedge s_clk);
      n_rst = 1'b0;
      repeat (2) @(negedge s_clk);
      n_rst = 1'b1;
      idle(4);
      e0 = err_seen;
      send_frame('{32'h01020304, 32'h05060708});
      idle(8);
      send_frame('{32'h090a0b0c, 32'h0d0e0f10});
      idle(6);
      chk("t6_sb_empty", 32'(sb.size()), 32'd0);
      chk("t6_no_err",   32'(err_seen - e0), 32'd0);
`ifdef PSI_RX_STATS_EN
      chk("t6_pkt_cnt",  {16'b0, pkt_cnt}, 32'd2);
      chk("t6_dw_total", dw_total, 32'd4);
      chk("t6_err_cnt",  {24'b0, err_cnt}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
